// File: rtl/lock_sys_pkg.sv
// Shared types and width helpers for the lock-system pulse stretcher.
package lock_sys_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HOLD = 2'd1,
        GAP  = 2'd2
    } stretch_state_t;

    // Bits needed to hold values 0..n-1, never less than one bit.
    function automatic int width_of(input int n);
        if (n <= 2) return 1;
        return $clog2(n);
    endfunction

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/pulse_stretcher_if.sv
// Command/status bundle of the pulse stretcher; master drives requests, slave is the stretcher.
// Handshake: no valid/ready; pulse_in and cancel are sampled on every rising clk edge and all status is registered.
interface pulse_stretcher_if
    import lock_sys_pkg::*;
#(
    parameter int PEND_W = 2
);
    logic              pulse_in;
    logic              cancel;
    logic              out;
    logic              busy;
    logic [PEND_W-1:0] pend_cnt;
    logic              overflow;
    stretch_state_t    state;

    modport master (
        output pulse_in, cancel,
        input  out, busy, pend_cnt, overflow, state
    );

    modport slave (
        input  pulse_in, cancel,
        output out, busy, pend_cnt, overflow, state
    );
endinterface

// File: rtl/load_down_counter.sv
// Loadable down-counter that stops at zero and flags it.
module load_down_counter #(
    parameter int W = 3
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic [W-1:0] cnt,
    output logic         zero
);
    always_ff @(posedge clk) begin
        if (reset)
            cnt <= '0;
        else if (load)
            cnt <= load_val;
        else if (dec && (cnt != '0))
            cnt <= cnt - 1'b1;
    end

    assign zero = (cnt == '0);
endmodule

// File: rtl/pulse_stretcher.sv
// Stretches single-cycle pulses into HOLD_CYCLES-long levels separated by GAP_CYCLES low cycles.
// Define PULSE_STRETCHER_RETRIGGER_EN to let pulses during HOLD extend the window instead of queueing.
module pulse_stretcher
    import lock_sys_pkg::*;
#(
    parameter int HOLD_CYCLES = 8,
    parameter int GAP_CYCLES  = 2,
    parameter int PEND_MAX    = 3
) (
    input  logic               clk,
    input  logic               reset,
    pulse_stretcher_if.slave   ifc
);
    localparam int CW = width_of(max_int(HOLD_CYCLES, GAP_CYCLES));
    localparam int PW = width_of(PEND_MAX + 1);
    localparam logic [CW-1:0] HOLD_LOAD = CW'(HOLD_CYCLES - 1);
    localparam logic [CW-1:0] GAP_LOAD  = CW'(GAP_CYCLES - 1);
    localparam logic [PW-1:0] PEND_FULL = PW'(PEND_MAX);

    if (HOLD_CYCLES < 1 || GAP_CYCLES < 1 || PEND_MAX < 1) begin : g_bad_params
        $error("pulse_stretcher: HOLD_CYCLES, GAP_CYCLES and PEND_MAX must all be >= 1");
    end

    stretch_state_t state, state_n;
    logic [PW-1:0]  pend, pend_n;
    logic           ovf, ovf_n;
    logic           out_q, busy_q;
    logic           cnt_load, cnt_dec, cnt_zero, enq;
    logic [CW-1:0]  cnt_val, cnt;

    load_down_counter #(.W(CW)) u_cnt (
        .clk      (clk),
        .reset    (reset),
        .load     (cnt_load),
        .load_val (cnt_val),
        .dec      (cnt_dec),
        .cnt      (cnt),
        .zero     (cnt_zero)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            pend   <= '0;
            ovf    <= 1'b0;
            out_q  <= 1'b0;
            busy_q <= 1'b0;
        end else begin
            state  <= state_n;
            pend   <= pend_n;
            ovf    <= ovf_n;
            out_q  <= (state_n == HOLD);
            busy_q <= (state_n != IDLE);
        end
    end

    always_comb begin
        state_n  = state;
        pend_n   = pend;
        ovf_n    = ovf;
        cnt_load = 1'b0;
        cnt_val  = '0;
        cnt_dec  = 1'b0;
        enq      = 1'b0;
        if (ifc.cancel) begin
            // Cancel wins over a simultaneous pulse; GAP keeps its count frozen this cycle.
            pend_n = '0;
            ovf_n  = 1'b0;
            if (state == HOLD) begin
                state_n  = GAP;
                cnt_load = 1'b1;
                cnt_val  = GAP_LOAD;
            end
        end else begin
            case (state)
                IDLE: begin
                    if (ifc.pulse_in) begin
                        state_n  = HOLD;
                        cnt_load = 1'b1;
                        cnt_val  = HOLD_LOAD;
                    end
                end
                HOLD: begin
`ifdef PULSE_STRETCHER_RETRIGGER_EN
                    if (ifc.pulse_in) begin
                        cnt_load = 1'b1;
                        cnt_val  = HOLD_LOAD;
                    end else if (cnt_zero) begin
                        state_n  = GAP;
                        cnt_load = 1'b1;
                        cnt_val  = GAP_LOAD;
                    end else begin
                        cnt_dec = 1'b1;
                    end
`else
                    enq = ifc.pulse_in;
                    if (cnt_zero) begin
                        state_n  = GAP;
                        cnt_load = 1'b1;
                        cnt_val  = GAP_LOAD;
                    end else begin
                        cnt_dec = 1'b1;
                    end
`endif
                end
                GAP: begin
                    if (!cnt_zero) begin
                        cnt_dec = 1'b1;
                        enq     = ifc.pulse_in;
                    end else if ((pend != '0) || ifc.pulse_in) begin
                        // A pulse on the last gap cycle is served directly, so pend only drops without one.
                        state_n  = HOLD;
                        cnt_load = 1'b1;
                        cnt_val  = HOLD_LOAD;
                        if ((pend != '0) && !ifc.pulse_in)
                            pend_n = pend - 1'b1;
                    end else begin
                        state_n = IDLE;
                    end
                end
                default: state_n = IDLE;
            endcase
            if (enq) begin
                if (pend != PEND_FULL)
                    pend_n = pend + 1'b1;
                else
                    ovf_n = 1'b1;
            end
        end
    end

    assign ifc.out      = out_q;
    assign ifc.busy     = busy_q;
    assign ifc.pend_cnt = pend;
    assign ifc.overflow = ovf;
    assign ifc.state    = state;
endmodule

// File: tb/tb_pulse_stretcher.sv
// Directed scoreboard bench for pulse_stretcher with HOLD=4, GAP=2, PEND_MAX=3.
module tb_pulse_stretcher;
    import lock_sys_pkg::*;

    localparam int W = 5;

    logic clk;
    logic reset;

    pulse_stretcher_if #(.PEND_W(2)) ifc ();

    pulse_stretcher #(
        .HOLD_CYCLES (4),
        .GAP_CYCLES  (2),
        .PEND_MAX    (3)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .ifc   (ifc.slave)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [W-1:0] exp_q[$];
    string        name_q[$];
    int           cyc_q[$];
    int           n_checks;
    int           n_fails;

    logic       e_out  [64];
    logic       e_busy [64];
    logic [1:0] e_pend [64];
    logic       e_ovf  [64];

    task automatic clr_exp();
        for (int i = 0; i < 64; i++) begin
            e_out[i] = 1'b0; e_busy[i] = 1'b0; e_pend[i] = 2'd0; e_ovf[i] = 1'b0;
        end
    endtask

    task automatic s_out(input int lo, input int hi);
        for (int i = lo; i <= hi; i++) e_out[i] = 1'b1;
    endtask

    task automatic s_busy(input int lo, input int hi);
        for (int i = lo; i <= hi; i++) e_busy[i] = 1'b1;
    endtask

    task automatic s_pend(input int lo, input int hi, input logic [1:0] v);
        for (int i = lo; i <= hi; i++) e_pend[i] = v;
    endtask

    task automatic s_ovf(input int lo, input int hi);
        for (int i = lo; i <= hi; i++) e_ovf[i] = 1'b1;
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        reset = 1'b1; ifc.pulse_in = 1'b0; ifc.cancel = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    // driver: cycle c drives bits [c] of the masks and queues the expected sample for cycle c
    task automatic run_test(input string name, input logic [63:0] pm, input logic [63:0] cm,
                            input logic [63:0] rm, input int n);
        for (int c = 0; c < n; c++) begin
            @(posedge clk); #1;
            ifc.pulse_in = pm[c];
            ifc.cancel   = cm[c];
            reset        = rm[c];
            exp_q.push_back({e_out[c], e_busy[c], e_pend[c], e_ovf[c]});
            name_q.push_back(name);
            cyc_q.push_back(c);
        end
        @(posedge clk); #1;
        ifc.pulse_in = 1'b0; ifc.cancel = 1'b0; reset = 1'b0;
    endtask

    // monitor / scoreboard
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            logic [W-1:0] e, a;
            string        nm;
            int           cy;
            e  = exp_q.pop_front();
            nm = name_q.pop_front();
            cy = cyc_q.pop_front();
            a  = {ifc.out, ifc.busy, ifc.pend_cnt, ifc.overflow};
            n_checks++;
            if (a !== e) begin
                n_fails++;
                $display("FAIL %s cycle %0d: got out=%0b busy=%0b pend=%0d ovf=%0b, expected out=%0b busy=%0b pend=%0d ovf=%0b",
                         nm, cy, a[4], a[3], a[2:1], a[0], e[4], e[3], e[2:1], e[0]);
            end
        end
    end

    initial begin
        n_checks = 0;
        n_fails  = 0;
        reset = 1'b1; ifc.pulse_in = 1'b0; ifc.cancel = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        clr_exp();
        run_test("reset_state", 64'h0, 64'h0, 64'h3, 4);
        do_reset();

        clr_exp(); s_out(1, 4); s_busy(1, 6);
        run_test("single", 64'h1, 64'h0, 64'h0, 9);
        do_reset();

        clr_exp(); s_out(1, 4); s_out(7, 10); s_out(13, 16); s_busy(1, 18);
        s_pend(2, 2, 2'd1); s_pend(3, 6, 2'd2); s_pend(7, 12, 2'd1);
        run_test("queue3", 64'h7, 64'h0, 64'h0, 20);
        do_reset();

        clr_exp(); s_out(1, 4); s_out(7, 10); s_out(13, 16); s_out(19, 22); s_busy(1, 24);
        s_pend(2, 2, 2'd1); s_pend(3, 3, 2'd2); s_pend(4, 6, 2'd3);
        s_pend(7, 12, 2'd2); s_pend(13, 18, 2'd1); s_ovf(5, 26);
        run_test("overflow", 64'h3F, 64'h1 << 26, 64'h0, 28);
        do_reset();

        clr_exp(); s_out(1, 4); s_out(7, 10); s_busy(1, 12);
        run_test("last_gap", 64'h41, 64'h0, 64'h0, 13);
        do_reset();

        clr_exp(); s_out(1, 3); s_busy(1, 5); s_pend(2, 2, 2'd1); s_pend(3, 3, 2'd2);
        run_test("cancel", 64'hF, 64'h8, 64'h0, 8);
        do_reset();

        clr_exp(); s_out(1, 2); s_busy(1, 2);
        run_test("reset_mid", 64'h1, 64'h0, 64'h4, 6);
        do_reset();

`ifdef PULSE_STRETCHER_RETRIGGER_EN
        clr_exp(); s_out(1, 7); s_busy(1, 9);
`else
        clr_exp(); s_out(1, 4); s_out(7, 10); s_busy(1, 12); s_pend(4, 6, 2'd1);
`endif
        run_test("retrigger", 64'h9, 64'h0, 64'h0, 13);

        for (int i = 0; i < 100 && exp_q.size() > 0; i++) @(posedge clk);
        if (exp_q.size() > 0) begin
            n_fails++;
            $display("FAIL drain: %0d expected samples left, required 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end
endmodule
